template_rom_matcher: RTL and testbench

- Streams one camera ROI (region of interest) of pixels against a fruit template held in the template ROM (the banana ROM and similar); sits directly upstream of the ROM.
- Drives the ROM address and consumes the ROM read data.
- Aligns the incoming pixels to the ROM read latency and accumulates the sum of absolute differences (SAD).
- Reports one score and one match flag per ROI to the classifier.

---
 rtl/template_rom_matcher.sv | 178 +++++++++++++++++
 tb/tb_template_rom_matcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/template_rom_matcher.sv
// template_rom_matcher: streams one ROI of pixels against a template ROM and
// accumulates the saturating sum of absolute differences (SAD). Produces one
// score/match pair per ROI.
// Optional macro TEMPLATE_MASK_EN: template words equal to 0 are transparent
// and not accumulated; match also requires more than TEMPLATE_LEN/4 counted
// pixels.
module template_rom_matcher #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 8,
  parameter int TEMPLATE_LEN = 1024,
  parameter int ROM_LATENCY  = 1,
  parameter int SCORE_WIDTH  = 18,
  parameter int THRESHOLD    = 20000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [DATA_WIDTH-1:0]  pix_data,
  output logic                   pix_ready,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_rd_data,
  output logic                   busy,
  output logic                   score_valid,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   match
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TEMPLATE_LEN - 1);
  localparam logic [1:0]            DRAIN_LAST = 2'(ROM_LATENCY);

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0]                  addr_reg;
  logic [1:0]                             drain_cnt_reg;
  logic [ROM_LATENCY-1:0]                 pipe_valid_reg;
  logic [ROM_LATENCY-1:0][DATA_WIDTH-1:0] pipe_pix_reg;
  logic [SCORE_WIDTH-1:0]                 acc_reg;
  logic                                   score_valid_reg;
  logic [SCORE_WIDTH-1:0]                 score_reg;
  logic                                   match_reg;

  logic                   accept;
  logic                   last_accept;
  logic                   run_entry;
  logic                   tail_valid;
  logic [DATA_WIDTH-1:0]  tail_pix;
  logic [DATA_WIDTH:0]    pix_ext;
  logic [DATA_WIDTH:0]    tmpl_ext;
  logic [DATA_WIDTH:0]    abs_diff;
  logic [SCORE_WIDTH:0]   acc_sum;
  logic [SCORE_WIDTH-1:0] acc_sat;
  logic                   add_en;
  logic                   below_threshold;
  logic                   match_next;

  // Next-state decode and handshake/status outputs
  always_comb begin
    state_next  = state_reg;
    pix_ready   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    run_entry   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          run_entry  = 1'b1;
        end
      end
      RUN: begin
        pix_ready   = 1'b1;
        busy        = 1'b1;
        accept      = pix_valid;
        last_accept = pix_valid && (addr_reg == LAST_ADDR);
        if (last_accept) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_reg == DRAIN_LAST) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Template address counter; holds on the final pixel so it never wraps
  always_ff @(posedge clk) begin
    if (rst || run_entry) addr_reg <= '0;
    else if (accept && !last_accept) addr_reg <= addr_reg + 1'b1;
  end

  assign rom_addr = addr_reg;

  // Drain timer: counts cycles spent in DRAIN so the last add has landed
  always_ff @(posedge clk) begin
    if (rst || state_reg != DRAIN) drain_cnt_reg <= '0;
    else                           drain_cnt_reg <= drain_cnt_reg + 1'b1;
  end

  // Pixel/tag delay line matching the ROM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg <= '0;
      pipe_pix_reg   <= '0;
    end else begin
      pipe_valid_reg[0] <= accept;
      pipe_pix_reg[0]   <= pix_data;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_pix_reg[i]   <= pipe_pix_reg[i-1];
      end
    end
  end

  assign tail_valid = pipe_valid_reg[ROM_LATENCY-1];
  assign tail_pix   = pipe_pix_reg[ROM_LATENCY-1];
  assign pix_ext    = {1'b0, tail_pix};
  assign tmpl_ext   = {1'b0, rom_rd_data};
  assign abs_diff   = (pix_ext >= tmpl_ext) ? (pix_ext - tmpl_ext) : (tmpl_ext - pix_ext);
  assign acc_sum    = {1'b0, acc_reg} + (SCORE_WIDTH+1)'(abs_diff);
  assign acc_sat    = acc_sum[SCORE_WIDTH] ? {SCORE_WIDTH{1'b1}} : acc_sum[SCORE_WIDTH-1:0];
  assign below_threshold = {{(64-SCORE_WIDTH){1'b0}}, acc_reg} < 64'(THRESHOLD);

`ifdef TEMPLATE_MASK_EN
  localparam logic [ADDR_WIDTH:0] QUARTER_LEN = (ADDR_WIDTH+1)'(TEMPLATE_LEN / 4);

  logic [ADDR_WIDTH:0] counted_reg;

  // A zero template word is background and does not contribute
  assign add_en     = (rom_rd_data != '0);
  assign match_next = below_threshold && (counted_reg > QUARTER_LEN);

  // Number of pixels that actually contributed to the score
  always_ff @(posedge clk) begin
    if (rst || run_entry) counted_reg <= '0;
    else if (tail_valid && add_en) counted_reg <= counted_reg + 1'b1;
  end
`else
  assign add_en     = 1'b1;
  assign match_next = below_threshold;
`endif

  // Saturating SAD accumulator
  always_ff @(posedge clk) begin
    if (rst || run_entry) acc_reg <= '0;
    else if (tail_valid && add_en) acc_reg <= acc_sat;
  end

  // Result registers: pulse on DONE, score/match held until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      score_valid_reg <= 1'b0;
      score_reg       <= '0;
      match_reg       <= 1'b0;
    end else begin
      score_valid_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        score_reg <= acc_reg;
        match_reg <= match_next;
      end
    end
  end

  assign score_valid = score_valid_reg;
  assign score       = score_reg;
  assign match       = match_reg;

endmodule

// File: tb/tb_template_rom_matcher.sv
// Testbench for template_rom_matcher: two instances (ROM latency 2 with an
// 18-bit score and THRESHOLD=80; ROM latency 1 with a 10-bit score) share one
// pixel stream and one template image; results are checked against a
// whole-ROI reference computed from the template and pixel arrays.
module tb_template_rom_matcher;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LEN = 16;
  localparam int SW0 = 18;
  localparam int SW1 = 10;
  localparam int TH0 = 80;
  localparam int TH1 = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;

  logic pix_ready0, pix_ready1, busy0, busy1, sv0, sv1, match0, match1;
  logic [AW-1:0] rom_addr0, rom_addr1;
  logic [DW-1:0] rom_rd_data0, rom_rd_data1, rom0_p1;
  logic [SW0-1:0] score0;
  logic [SW1-1:0] score1;

  logic [DW-1:0] rom_mem [LEN];
  logic [DW-1:0] px [LEN];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int sv0_count = 0, sv1_count = 0, sv0_cyc = 0;
  int last_acc_edge = 0, addr_bad = 0, n_acc = 0;
  logic ready_after, busy_after;
  longint e0s, e1s;
  bit e0m, e1m;

  template_rom_matcher #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TEMPLATE_LEN(LEN),
    .ROM_LATENCY(2), .SCORE_WIDTH(SW0), .THRESHOLD(TH0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready0), .rom_addr(rom_addr0), .rom_rd_data(rom_rd_data0),
    .busy(busy0), .score_valid(sv0), .score(score0), .match(match0)
  );

  template_rom_matcher #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TEMPLATE_LEN(LEN),
    .ROM_LATENCY(1), .SCORE_WIDTH(SW1), .THRESHOLD(TH1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready1), .rom_addr(rom_addr1), .rom_rd_data(rom_rd_data1),
    .busy(busy1), .score_valid(sv1), .score(score1), .match(match1)
  );

  always #5 clk = ~clk;

  // Behavioural template ROMs: two-cycle and one-cycle read latency
  always @(posedge clk) begin
    rom0_p1      <= rom_mem[rom_addr0];
    rom_rd_data0 <= rom0_p1;
    rom_rd_data1 <= rom_mem[rom_addr1];
    cyc          <= cyc + 1;
  end

  // Result monitor
  always @(negedge clk) begin
    if (sv0) begin sv0_count++; sv0_cyc = cyc; end
    if (sv1) sv1_count++;
  end

  // Reference: SAD over the whole ROI, clamped to the score range
  task automatic model(input int sw, input int thr, output longint s, output bit m);
    longint sum;
    longint cap;
    int counted;
    int d;
    sum = 0;
    counted = 0;
    for (int i = 0; i < LEN; i++) begin
      d = (int'(px[i]) > int'(rom_mem[i])) ? int'(px[i]) - int'(rom_mem[i])
                                           : int'(rom_mem[i]) - int'(px[i]);
`ifdef TEMPLATE_MASK_EN
      if (rom_mem[i] == 0) continue;
      counted++;
`endif
      sum += d;
    end
    cap = (longint'(1) << sw) - 1;
    s = (sum > cap) ? cap : sum;
    m = (s < thr);
`ifdef TEMPLATE_MASK_EN
    m = m && (counted > LEN / 4);
`endif
  endtask

  // Drive one ROI: mode 0 continuous, 1 alternating gaps, 2 random gaps plus stray starts
  task automatic run_roi(input int mode);
    int guard;
    sv0_count = 0; sv1_count = 0; addr_bad = 0; n_acc = 0; guard = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n_acc < LEN && guard < 400) begin
      case (mode)
        0: pix_valid = 1'b1;
        1: pix_valid = (guard % 2 == 0);
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) start = ($urandom_range(0, 3) == 0);
      pix_data = px[n_acc];
      if (pix_ready0 && rom_addr0 != AW'(n_acc)) addr_bad++;
      if (pix_valid && pix_ready0) begin
        n_acc++;
        last_acc_edge = cyc + 1;
      end
      guard++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    start = 1'b0;
    ready_after = pix_ready0;
    busy_after = busy0;
    repeat (12) @(negedge clk);
    model(SW0, TH0, e0s, e0m);
    model(SW1, TH1, e1s, e1m);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pix_ready0 !== 1'b0 || busy0 !== 1'b0 || sv0 !== 1'b0 || rom_addr0 !== '0 ||
        score0 !== '0 || match0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values got ready=%b busy=%b sv=%b addr=%0d score=%0d match=%b want all 0",
               pix_ready0, busy0, sv0, rom_addr0, score0, match0);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy0 !== 1'b0 || sv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle got busy=%b sv=%b want 0 0", busy0, sv0);
    end
  endtask

  task automatic test_equal;
    for (int i = 0; i < LEN; i++) begin rom_mem[i] = DW'(10 * (i + 1)); px[i] = rom_mem[i]; end
    run_roi(0);
    tests_run++;
    if (sv0_count !== 1 || sv1_count !== 1) begin
      tests_failed++;
      $display("FAIL equal_pulses got %0d/%0d want 1/1", sv0_count, sv1_count);
    end
    tests_run++;
    if (sv0_cyc - last_acc_edge !== 4) begin
      tests_failed++;
      $display("FAIL equal_latency got %0d want 4", sv0_cyc - last_acc_edge);
    end
    tests_run++;
    if (score0 !== 0 || match0 !== 1'b1 || score1 !== 0 || match1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL equal_score got %0d/%b %0d/%b want 0/1 0/1", score0, match0, score1, match1);
    end
    tests_run++;
    if (ready_after !== 1'b0 || busy_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL equal_drain got ready=%b busy=%b want 0 1", ready_after, busy_after);
    end
  endtask

  task automatic test_offset;
    for (int i = 0; i < LEN; i++) begin rom_mem[i] = DW'(10 * (i + 1)); px[i] = rom_mem[i] + 8'd5; end
    run_roi(0);
    tests_run++;
    if (score0 !== 18'd80 || match0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL offset_strict got %0d/%b want 80/0", score0, match0);
    end
    tests_run++;
    if (score1 !== SW1'(e1s) || match1 !== e1m) begin
      tests_failed++;
      $display("FAIL offset_dut1 got %0d/%b want %0d/%b", score1, match1, e1s, e1m);
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < LEN; i++) begin rom_mem[i] = DW'(10 * (i + 1)); px[i] = rom_mem[i] + 8'd5; end
    run_roi(1);
    tests_run++;
    if (addr_bad !== 0) begin
      tests_failed++;
      $display("FAIL gaps_addr_hold got %0d bad cycles want 0", addr_bad);
    end
    tests_run++;
    if (score0 !== SW0'(e0s) || score1 !== SW1'(e1s) || sv0_count !== 1) begin
      tests_failed++;
      $display("FAIL gaps_score got %0d %0d n=%0d want %0d %0d n=1", score0, score1, sv0_count, e0s, e1s);
    end
    tests_run++;
    if (sv0_cyc - last_acc_edge !== 4) begin
      tests_failed++;
      $display("FAIL gaps_latency got %0d want 4", sv0_cyc - last_acc_edge);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < LEN; i++) begin rom_mem[i] = '0; px[i] = 8'd255; end
    run_roi(0);
    tests_run++;
    if (score1 !== SW1'(e1s) || match1 !== e1m) begin
      tests_failed++;
      $display("FAIL saturate_dut1 got %0d/%b want %0d/%b", score1, match1, e1s, e1m);
    end
    tests_run++;
    if (score0 !== SW0'(e0s) || match0 !== e0m) begin
      tests_failed++;
      $display("FAIL saturate_dut0 got %0d/%b want %0d/%b", score0, match0, e0s, e0m);
    end
  endtask

  task automatic test_mask_pattern;
    for (int i = 0; i < LEN; i++) begin rom_mem[i] = (i < 12) ? 8'd0 : 8'd50; px[i] = 8'd60; end
    run_roi(0);
    tests_run++;
    if (score0 !== SW0'(e0s) || match0 !== e0m || score1 !== SW1'(e1s) || match1 !== e1m) begin
      tests_failed++;
      $display("FAIL mask_pattern got %0d/%b %0d/%b want %0d/%b %0d/%b",
               score0, match0, score1, match1, e0s, e0m, e1s, e1m);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < LEN; i++) begin rom_mem[i] = DW'(10 * (i + 1)); px[i] = rom_mem[i]; end
    sv0_count = 0; sv1_count = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1; pix_data = px[i] + 8'd3;
      @(negedge clk);
    end
    pix_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tests_run++;
    if (busy0 !== 1'b0 || pix_ready0 !== 1'b0 || rom_addr0 !== '0 || score0 !== '0) begin
      tests_failed++;
      $display("FAIL abort_reset got busy=%b ready=%b addr=%0d score=%0d want 0 0 0 0",
               busy0, pix_ready0, rom_addr0, score0);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (sv0_count !== 0 || sv1_count !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_pulse got %0d/%0d want 0/0", sv0_count, sv1_count);
    end
    run_roi(0);
    tests_run++;
    if (score0 !== 0 || score1 !== 0 || sv0_count !== 1) begin
      tests_failed++;
      $display("FAIL abort_rerun got %0d %0d n=%0d want 0 0 n=1", score0, score1, sv0_count);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LEN; i++) begin
        rom_mem[i] = DW'($urandom_range(0, 255));
        px[i] = DW'($urandom_range(0, 255));
      end
      run_roi(2);
      tests_run++;
      if (sv0_count !== 1 || sv1_count !== 1 || sv0_cyc - last_acc_edge !== 4) begin
        tests_failed++;
        $display("FAIL random%0d_timing got n=%0d/%0d lat=%0d want n=1/1 lat=4",
                 r, sv0_count, sv1_count, sv0_cyc - last_acc_edge);
      end
      tests_run++;
      if (score0 !== SW0'(e0s) || match0 !== e0m || score1 !== SW1'(e1s) || match1 !== e1m) begin
        tests_failed++;
        $display("FAIL random%0d_score got %0d/%b %0d/%b want %0d/%b %0d/%b",
                 r, score0, match0, score1, match1, e0s, e0m, e1s, e1m);
      end
      tests_run++;
      if (addr_bad !== 0) begin
        tests_failed++;
        $display("FAIL random%0d_addr got %0d bad cycles want 0", r, addr_bad);
      end
    end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_offset;
    test_gaps;
    test_saturate;
    test_mask_pattern;
    test_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
